i2s_mic_sched: RTL and testbench
================================

I2S_MIC_SCHED -- requirements
Module: i2s_mic_sched

Interface
REQ-001 Parameter DATA_W, default 24: sample width in bits.
REQ-002 Parameter NCH, default 8: number of mono channels (4 stereo I2S receivers x L/R).
REQ-003 Parameter CH_W, default 3: channel index width (CH_W >= clog2(NCH)).
REQ-004 clk  in  1: single system clock; all logic on rising edge.
REQ-005 rst  in  1: reset, synchronous, active-high.
REQ-006 frame_stb  in  1: one-cycle pulse marking a new complete sample set on ch_data/ch_detect.
REQ-007 ch_data  in  NCH*DATA_W: packed samples, channel i at bits [i*DATA_W +: DATA_W].
REQ-008 ch_detect  in  NCH: per-channel microphone-present flags from the receivers.
REQ-009 ch_enable  in  NCH: software channel mask.
REQ-010 out_data  out  DATA_W: current output word.
REQ-011 out_ch  out  CH_W: channel index of out_data.
REQ-012 out_valid  out  1: out_data/out_ch/out_last valid.
REQ-013 out_ready  in  1: downstream accept; a transfer occurs on a cycle with out_valid & out_ready.
REQ-014 out_last  out  1: marks the final word of a frame.
REQ-015 busy  out  1: high whenever state != IDLE.
REQ-016 overrun  out  1: sticky dropped-frame flag.
REQ-017 ovr_clr  in  1: clears overrun.

Function
REQ-018 FSM states: IDLE, SCAN, SEND; IDLE is the only state that accepts frame_stb.
REQ-019 IDLE & frame_stb: snapshot ch_data into a frame buffer and pend = ch_detect & ch_enable; go to SCAN if pend != 0, else stay IDLE (empty frame, no output).
REQ-020 SCAN (one cycle): register the lowest set index of pend into sel; load out_data = buffer[sel], out_ch = sel, out_last = (pend has exactly one bit set); assert out_valid; go to SEND.
REQ-021 SEND: out_valid held high; out_data/out_ch/out_last stable until transfer.
REQ-022 On transfer in SEND: clear pend[sel]; if out_last, deassert out_valid and go to IDLE; else go to SCAN.
REQ-023 Latency: out_valid first rises 2 cycles after the frame_stb cycle; each later word 2 cycles after the previous transfer.
REQ-024 Channels are emitted in strictly ascending index order; each eligible channel exactly once per frame.
REQ-025 The snapshot is immune to ch_data/ch_detect/ch_enable changes after the capture cycle.
REQ-026 frame_stb while busy: frame dropped, overrun set to 1, in-progress frame unaffected.
REQ-027 ovr_clr sets overrun to 0; if ovr_clr and a drop occur in the same cycle, overrun = 1 (set wins).
REQ-028 frame_stb on the same cycle as the final transfer is dropped (state is still SEND) and sets overrun.
REQ-029 out_valid never deasserts without a transfer except by rst.

Reset
REQ-030 rst (sync, active-high) forces: state IDLE, pend 0, out_valid 0, out_last 0, out_data 0, out_ch 0, overrun 0, busy 0, frame counter 0.
REQ-031 rst mid-frame abandons the frame with no further output; rst takes priority over every other input in the same cycle.

Configuration
REQ-032 Macro I2S_MIC_SCHED_HEADER_EN controls a per-frame header word.
REQ-033 Defined: each non-empty frame is preceded by a header word: out_ch = all ones, out_data[7:0] = 8-bit frame counter, out_data[8 +: NCH] = pend snapshot, other bits 0, out_last = 0; header is sent via the same handshake, then channel words follow; adds 2 cycles per frame; the counter increments on each header transfer and wraps 255->0.
REQ-034 Not defined: no header, no frame counter logic; behaviour exactly per REQ-018..REQ-029.

Verification
REQ-035 detect=8'hFF, enable=8'h05, out_ready=1, ch0=24'h000011, ch2=24'h000033 -> words (ch0,24'h000011,last 0), (ch2,24'h000033,last 1); first out_valid 2 cycles after frame_stb.
REQ-036 detect=8'h80, enable=8'hFF, out_ready held 0 for 10 cycles -> out_valid=1, out_ch=7, out_last=1 stable for all 10 cycles; one transfer when out_ready rises.
REQ-037 detect&enable=0 -> busy stays 0, no out_valid, overrun stays 0.
REQ-038 second frame_stb 1 cycle after the first (mask 8'h03) -> overrun=1, only 2 words emitted; ovr_clr -> overrun=0.
REQ-039 rst asserted during SEND of ch 1 of 3 -> next cycle out_valid=0, busy=0; next frame_stb restarts from lowest channel.
REQ-040 With I2S_MIC_SCHED_HEADER_EN, mask 8'h01, 3 frames -> headers with counter 0,1,2 and data[15:8]=8'h01, each followed by one ch0 word with last=1.

Source files
------------

// File: rtl/i2s_mic_sched_if.sv
// Bundle for i2s_mic_sched: frame input, output word handshake and status/control.
interface i2s_mic_sched_if #(
    parameter int DATA_W = 24,
    parameter int NCH    = 8,
    parameter int CH_W   = 3
);
    logic                    frame_stb;
    logic [NCH*DATA_W-1:0]   ch_data;
    logic [NCH-1:0]          ch_detect;
    logic [NCH-1:0]          ch_enable;
    logic [DATA_W-1:0]       out_data;
    logic [CH_W-1:0]         out_ch;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic                    busy;
    logic                    overrun;
    logic                    ovr_clr;

    modport master (
        output frame_stb, ch_data, ch_detect, ch_enable, out_ready, ovr_clr,
        input  out_data, out_ch, out_valid, out_last, busy, overrun
    );

    modport slave (
        input  frame_stb, ch_data, ch_detect, ch_enable, out_ready, ovr_clr,
        output out_data, out_ch, out_valid, out_last, busy, overrun
    );
endinterface

// File: rtl/i2s_mic_sched.sv
// Serialises a snapshot of NCH mic samples into an ascending-channel word stream.
// Define I2S_MIC_SCHED_HEADER_EN to prefix each non-empty frame with a header word.
module i2s_mic_sched #(
    parameter int DATA_W = 24,
    parameter int NCH    = 8,
    parameter int CH_W   = 3
) (
    input logic             clk,
    input logic             rst,
    i2s_mic_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, SEND} state_t;

    state_t                state_q, state_d;
    logic [NCH*DATA_W-1:0] buf_q, buf_d;
    logic [NCH-1:0]        pend_q, pend_d;
    logic [CH_W-1:0]       sel_q, sel_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic [CH_W-1:0]       out_ch_q, out_ch_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  overrun_q, overrun_d;
    logic [CH_W-1:0]       low;
    logic                  one_hot;
    logic                  xfer;
    logic                  drop;
`ifdef I2S_MIC_SCHED_HEADER_EN
    logic                  hdr_q, hdr_d;
    logic [7:0]            cnt_q, cnt_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            pend_q      <= '0;
            sel_q       <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef I2S_MIC_SCHED_HEADER_EN
            hdr_q       <= 1'b0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            pend_q      <= pend_d;
            sel_q       <= sel_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overrun_q   <= overrun_d;
`ifdef I2S_MIC_SCHED_HEADER_EN
            hdr_q       <= hdr_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Priority pick of the lowest pending channel
    always_comb begin
        low = '0;
        for (int unsigned i = NCH; i > 0; i--) begin
            if (pend_q[i-1]) low = CH_W'(i - 1);
        end
        one_hot = (pend_q != '0) && ((pend_q & (pend_q - NCH'(1))) == '0);
    end

    assign xfer = (state_q == SEND) && out_valid_q && bus.out_ready;
    assign drop = bus.frame_stb && (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.frame_stb && ((bus.ch_detect & bus.ch_enable) != '0)) state_d = SCAN;
            SCAN: state_d = SEND;
            SEND: if (xfer) state_d = out_last_q ? IDLE : SCAN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        buf_d       = buf_q;
        pend_d      = pend_q;
        sel_d       = sel_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        overrun_d   = drop ? 1'b1 : (bus.ovr_clr ? 1'b0 : overrun_q);
`ifdef I2S_MIC_SCHED_HEADER_EN
        hdr_d       = hdr_q;
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.frame_stb) begin
                    buf_d  = bus.ch_data;
                    pend_d = bus.ch_detect & bus.ch_enable;
`ifdef I2S_MIC_SCHED_HEADER_EN
                    hdr_d  = ((bus.ch_detect & bus.ch_enable) != '0);
`endif
                end
            end
            SCAN: begin
                out_valid_d = 1'b1;
`ifdef I2S_MIC_SCHED_HEADER_EN
                if (hdr_q) begin
                    out_data_d          = '0;
                    out_data_d[7:0]     = cnt_q;
                    out_data_d[8 +: NCH] = pend_q;
                    out_ch_d            = '1;
                    out_last_d          = 1'b0;
                end else
`endif
                begin
                    sel_d      = low;
                    out_data_d = buf_q[int'(low)*DATA_W +: DATA_W];
                    out_ch_d   = low;
                    out_last_d = one_hot;
                end
            end
            SEND: begin
                if (xfer) begin
                    out_valid_d = 1'b0;
`ifdef I2S_MIC_SCHED_HEADER_EN
                    if (hdr_q) begin
                        hdr_d = 1'b0;
                        cnt_d = cnt_q + 8'd1;
                    end else
`endif
                    pend_d[sel_q] = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_i2s_mic_sched.sv
// Directed self-checking bench for i2s_mic_sched (default and header builds).
module tb_i2s_mic_sched;
    localparam int DATA_W = 24;
    localparam int NCH    = 8;
    localparam int CH_W   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;
    int   words;

    i2s_mic_sched_if #(.DATA_W(DATA_W), .NCH(NCH), .CH_W(CH_W)) bus ();

    i2s_mic_sched #(.DATA_W(DATA_W), .NCH(NCH), .CH_W(CH_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel i carries 0x11*(i+1); inv flips every bit to expose late sampling
    task automatic load_data(input bit inv);
        logic [NCH*DATA_W-1:0] d;
        for (int i = 0; i < NCH; i++) d[i*DATA_W +: DATA_W] = DATA_W'(17 * (i + 1));
        bus.ch_data = inv ? ~d : d;
    endtask

    task automatic chk_word(input string tag, input int ch, input logic [23:0] data, input bit last);
        chk({tag, "_v"}, bus.out_valid, 1);
        chk({tag, "_ch"}, bus.out_ch, ch);
        chk({tag, "_d"}, bus.out_data, data);
        chk({tag, "_l"}, bus.out_last, last);
    endtask

    initial begin
        bus.frame_stb = 0;
        bus.ch_detect = '0;
        bus.ch_enable = '0;
        bus.out_ready = 0;
        bus.ovr_clr   = 0;
        load_data(0);
        tick(); tick();
        rst = 0;
        tick();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ovr", bus.overrun, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_ch", bus.out_ch, 0);
        chk("rst_last", bus.out_last, 0);

`ifdef I2S_MIC_SCHED_HEADER_EN
        bus.ch_detect = 8'hFF; bus.ch_enable = 8'h01; bus.out_ready = 1;
        for (int f = 0; f < 3; f++) begin
            bus.frame_stb = 1; tick(); bus.frame_stb = 0;
            chk("h_lat", bus.out_valid, 0);
            tick();
            chk_word("h_hdr", 7, 24'h000100 | 24'(f), 0);
            tick();
            chk("h_gap", bus.out_valid, 0);
            tick();
            chk_word("h_ch0", 0, 24'h000011, 1);
            tick();
            chk("h_idle", bus.busy, 0);
        end
`else
        // Two eligible channels, ready always high
        bus.ch_detect = 8'hFF; bus.ch_enable = 8'h05; bus.out_ready = 1;
        bus.frame_stb = 1; tick(); bus.frame_stb = 0;
        load_data(1); bus.ch_detect = '0;
        chk("t1_lat", bus.out_valid, 0);
        chk("t1_busy", bus.busy, 1);
        tick();
        chk_word("t1_w0", 0, 24'h000011, 0);
        tick();
        chk("t1_gap", bus.out_valid, 0);
        tick();
        chk_word("t1_w1", 2, 24'h000033, 1);
        tick();
        chk("t1_end_v", bus.out_valid, 0);
        chk("t1_end_b", bus.busy, 0);

        // Backpressure on a single word
        load_data(0);
        bus.ch_detect = 8'h80; bus.ch_enable = 8'hFF; bus.out_ready = 0;
        bus.frame_stb = 1; tick(); bus.frame_stb = 0;
        tick();
        for (int i = 0; i < 10; i++) chk_word("t2_hold", 7, 24'h000088, 1);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_word("t2_hold", 7, 24'h000088, 1);
        end
        bus.out_ready = 1; tick();
        chk("t2_done", bus.out_valid, 0);
        chk("t2_idle", bus.busy, 0);

        // Empty frame
        bus.ch_detect = 8'h0F; bus.ch_enable = 8'hF0;
        bus.frame_stb = 1; tick(); bus.frame_stb = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_busy", bus.busy, 0);
            chk("t3_valid", bus.out_valid, 0);
            tick();
        end
        chk("t3_ovr", bus.overrun, 0);

        // Back-to-back strobe is dropped
        bus.ch_detect = 8'h03; bus.ch_enable = 8'hFF;
        bus.frame_stb = 1; tick();
        bus.ch_detect = 8'hFF;
        tick(); bus.frame_stb = 0;
        chk("t4_ovr", bus.overrun, 1);
        words = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) words++;
            tick();
        end
        chk("t4_words", words, 2);
        chk("t4_ovr_sticky", bus.overrun, 1);
        bus.ovr_clr = 1; tick(); bus.ovr_clr = 0;
        chk("t4_clr", bus.overrun, 0);

        // Set wins over clear; strobe on final transfer is dropped
        bus.ch_detect = 8'h01; bus.out_ready = 0;
        bus.frame_stb = 1; tick(); bus.frame_stb = 0; tick();
        bus.frame_stb = 1; bus.ovr_clr = 1; tick();
        bus.frame_stb = 0; bus.ovr_clr = 0;
        chk("t5_setwins", bus.overrun, 1);
        bus.ovr_clr = 1; tick(); bus.ovr_clr = 0;
        chk("t5_clr", bus.overrun, 0);
        bus.out_ready = 1; bus.frame_stb = 1; tick(); bus.frame_stb = 0;
        chk("t5_lastdrop", bus.overrun, 1);
        tick(); tick();
        chk("t5_nofr_b", bus.busy, 0);
        chk("t5_nofr_v", bus.out_valid, 0);

        // Reset mid-frame, with a simultaneous strobe, then restart
        bus.ch_detect = 8'h07; bus.out_ready = 0;
        bus.frame_stb = 1; tick(); bus.frame_stb = 0; tick();
        bus.out_ready = 1; tick(); bus.out_ready = 0; tick();
        chk_word("t6_ch1", 1, 24'h000022, 0);
        rst = 1; bus.frame_stb = 1; tick(); rst = 0; bus.frame_stb = 0;
        chk("t6_rst_v", bus.out_valid, 0);
        chk("t6_rst_b", bus.busy, 0);
        chk("t6_rst_o", bus.overrun, 0);
        tick(); tick();
        chk("t6_quiet", bus.out_valid, 0);
        bus.out_ready = 1;
        bus.frame_stb = 1; tick(); bus.frame_stb = 0; tick();
        chk_word("t6_restart", 0, 24'h000011, 0);
`endif
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
